// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ byte-stream requesters. Ownership
// is granted round-robin and held for a whole packet (until the byte flagged
// with req_last has been issued), so packets from different requesters never
// interleave. Each byte is handed to the UART as a one-cycle start strobe,
// followed by one GAP cycle that gives the requester time to present its next
// byte. An owner that stops requesting for IDLE_TIMEOUT consecutive cycles
// loses the grant (0 disables this).
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   req[i]           requester i has a valid byte
//   req_data         byte of requester i on bits [8i+7:8i]
//   req_last[i]      requester i's current byte ends its packet
//   req_ack[i]       one-cycle pulse: requester i's byte was consumed
//   grant            one-hot current owner, zero when none
//   busy             an owner is held or a transfer is in progress
//   uart_tx_full     UART TX FIFO cannot accept a byte this cycle
//   uart_tx_start    one-cycle write strobe to the UART
//   uart_tx_data_in  byte presented with uart_tx_start
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  input  logic                 uart_tx_full,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data_in
);

  localparam int IW = $clog2(N_REQ);
  // A disabled timeout still gets a 1-bit counter so no zero-width vectors exist.
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,  // no owner
    ST_OWN,   // owner held, waiting to issue a byte
    ST_GAP    // cycle after an issue; requester inputs are not sampled
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_q, data_d;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    idx;
  logic [7:0]       req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin search starting at ptr+1. Walking the offsets from farthest
  // to nearest lets the nearest requesting index win without a break.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

  // Idle counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end

      ST_OWN: begin
        if (req[owner_q]) begin
          // A requester stalled by a full FIFO is still active, so the idle
          // count restarts; only a dropped req counts toward revocation.
          cnt_d = '0;
          if (!uart_tx_full) begin
            data_d  = req_bytes[owner_q];
            start_d = 1'b1;
            ack_d   = grant_q;
            last_d  = req_last[owner_q];
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_inc;
          if (IDLE_TIMEOUT != 0 && cnt_inc == CNT_MAX) begin
            grant_d = '0;
            ptr_d   = owner_q;
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (last_q) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWN;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || (grant_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);  // requester 0 wins the first arbitration
      grant_q <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign req_ack         = ack_q;
  assign grant           = grant_q;
  assign busy            = busy_q;
  assign uart_tx_start   = start_q;
  assign uart_tx_data_in = data_q;

endmodule
